// File: rtl/range_seq_driver.sv
// Range-finder stimulus/checker: buffers samples, replays them as one go/finish framed
// run, captures the returned range/error and compares it against its own max-min.
module range_seq_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       start,
  output logic                       reject,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           data_out,
  output logic                       go,
  output logic                       finish,
  input  logic [WIDTH-1:0]           range_in,
  input  logic                       error_in,
  output logic [WIDTH-1:0]           result,
  output logic                       result_err,
  output logic [WIDTH-1:0]           expected,
  output logic                       mismatch
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, STREAM = 2'd2, LAST = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] buf_r [DEPTH];
  logic [CW-1:0]    count_s, n_r;
  logic [AW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] min_r, max_r, min_s, max_s, data_s, span_s;
  logic             wr_en_s, accept_s, refuse_s;

  // Buffer control: start/clear/load decisions, only acted on in IDLE
  always_comb begin
    accept_s = (state_r == IDLE) && start && (count >= CW'(2));
    refuse_s = (state_r == IDLE) && start && (count < CW'(2));
    wr_en_s  = 1'b0;
    count_s  = count;
    if (state_r != IDLE) begin
      count_s = count;
    end else if (clear) begin
      count_s = {CW{1'b0}};
    end else if (wr_valid && (count < CW'(DEPTH))) begin
      wr_en_s = 1'b1;
      count_s = count + CW'(1);
    end else begin
      count_s = count;
    end
  end

  // Next-state logic; n_r is the run length latched when the run was accepted
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = FIRST;
        else          state_s = IDLE;
      end
      FIRST: begin
        if (n_r > CW'(2)) state_s = STREAM;
        else              state_s = LAST;
      end
      STREAM: begin
        if (CW'(idx_r) == n_r - CW'(2)) state_s = LAST;
        else                            state_s = STREAM;
      end
      LAST:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, plus running min/max of what is played
  always_comb begin
    case (state_s)
      FIRST:        idx_s = {AW{1'b0}};
      STREAM, LAST: idx_s = idx_r + AW'(1);
      default:      idx_s = {AW{1'b0}};
    endcase
    if (state_s != IDLE) data_s = buf_r[idx_s];
    else                 data_s = {WIDTH{1'b0}};
    if (state_s == FIRST) begin
      min_s = data_s;
      max_s = data_s;
    end else if (state_s != IDLE) begin
      min_s = (data_s < min_r) ? data_s : min_r;
      max_s = (data_s > max_r) ? data_s : max_r;
    end else begin
      min_s = min_r;
      max_s = max_r;
    end
    span_s = max_r - min_r;
  end

  // Sample storage; appends land above the played entries so a run is never disturbed
  always_ff @(posedge clock) begin
    if (wr_en_s) buf_r[count[AW-1:0]] <= wr_data;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Registered outputs and per-run bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= {CW{1'b0}};
      wr_ready   <= 1'b1;
      n_r        <= {CW{1'b0}};
      idx_r      <= {AW{1'b0}};
      min_r      <= {WIDTH{1'b0}};
      max_r      <= {WIDTH{1'b0}};
      data_out   <= {WIDTH{1'b0}};
      go         <= 1'b0;
      finish     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject     <= 1'b0;
      result     <= {WIDTH{1'b0}};
      result_err <= 1'b0;
      expected   <= {WIDTH{1'b0}};
      mismatch   <= 1'b0;
    end else begin
      count    <= count_s;
      wr_ready <= (state_s == IDLE) && (count_s < CW'(DEPTH));
      idx_r    <= idx_s;
      min_r    <= min_s;
      max_r    <= max_s;
      data_out <= data_s;
      go       <= (state_s == FIRST);
      finish   <= (state_s == LAST);
      busy     <= (state_s != IDLE);
      done     <= (state_r == LAST);
      reject   <= refuse_s;
      if (accept_s) begin
        n_r        <= count;
        result_err <= 1'b0;
      end else if (state_r != IDLE) begin
        result_err <= result_err | error_in;
      end
      // LAST closing edge: min/max already include the final sample
      if (state_r == LAST) begin
        result   <= range_in;
        expected <= span_s;
        mismatch <= (range_in != span_s) | result_err | error_in;
      end
    end
  end

endmodule

// File: tb/tb_range_seq_driver.sv
// Self-checking bench for range_seq_driver: a queue-based run-schedule model is
// compared against every output on every falling edge, plus directed literal checks.
module tb_range_seq_driver;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic [WIDTH-1:0] wr_data = 8'd0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] range_in = 8'd0;
  logic             error_in = 1'b0;
  logic             wr_ready, reject, busy, done, go, finish, result_err, mismatch;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_out, result, expected;

  range_seq_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear(clear), .count(count), .start(start),
    .reject(reject), .busy(busy), .done(done), .data_out(data_out), .go(go),
    .finish(finish), .range_in(range_in), .error_in(error_in), .result(result),
    .result_err(result_err), .expected(expected), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: buffer as a queue; an accepted run is a snapshot plus the edge it began on
  int   q[$];
  int   run_s[$];
  bit   run_on;
  int   run_k, run_n, ecyc;
  bit   rng_bad;
  logic m_go, m_finish, m_busy, m_done, m_reject, m_wr_ready, m_result_err, m_mismatch;
  logic [WIDTH-1:0] m_data, m_result, m_expected;
  logic [CW-1:0]    m_count;

  function automatic int span(input int s[$]);
    int mn, mx;
    mn = 255;
    mx = 0;
    foreach (s[i]) begin
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
    end
    return mx - mn;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, required %0d", name, ecyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    run_s.delete();
    run_on = 1'b0;
    m_go = 1'b0; m_finish = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_reject = 1'b0;
    m_wr_ready = 1'b1; m_result_err = 1'b0; m_mismatch = 1'b0;
    m_data = 8'd0; m_result = 8'd0; m_expected = 8'd0; m_count = '0;
  endtask

  // Advance the model across one rising edge, then derive next-cycle outputs
  task automatic model_edge();
    int off;
    ecyc++;
    m_done = 1'b0;
    m_reject = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (run_on) begin
      m_result_err = m_result_err | error_in;
      if (ecyc - run_k == run_n) begin
        run_on       = 1'b0;
        m_done       = 1'b1;
        m_result     = range_in;
        m_expected   = 8'(span(run_s));
        m_mismatch   = (int'(range_in) != span(run_s)) || m_result_err;
      end
    end else begin
      if (start) begin
        if (q.size() >= 2) begin
          run_on = 1'b1;
          run_k  = ecyc;
          run_s  = q;
          run_n  = q.size();
          m_result_err = 1'b0;
        end else begin
          m_reject = 1'b1;
        end
      end
      if (clear) q.delete();
      else if (wr_valid && q.size() < DEPTH) q.push_back(int'(wr_data));
    end
    if (run_on) begin
      off      = ecyc + 1 - run_k;
      m_data   = 8'(run_s[off-1]);
      m_go     = (off == 1);
      m_finish = (off == run_n);
      m_busy   = 1'b1;
    end else begin
      m_data = 8'd0; m_go = 1'b0; m_finish = 1'b0; m_busy = 1'b0;
    end
    m_wr_ready = !run_on && (q.size() < DEPTH);
    m_count    = CW'(q.size());
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clock) begin
    check("go", 32'(go), 32'(m_go));
    check("finish", 32'(finish), 32'(m_finish));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("reject", 32'(reject), 32'(m_reject));
    check("data_out", 32'(data_out), 32'(m_data));
    check("wr_ready", 32'(wr_ready), 32'(m_wr_ready));
    check("count", 32'(count), 32'(m_count));
    check("result", 32'(result), 32'(m_result));
    check("result_err", 32'(result_err), 32'(m_result_err));
    check("expected", 32'(expected), 32'(m_expected));
    check("mismatch", 32'(mismatch), 32'(m_mismatch));
  end

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
    if (run_on) range_in = 8'(span(run_s) ^ (rng_bad ? 1 : 0));
    else        range_in = 8'($urandom_range(0, 255));
  endtask

  task automatic load(input logic [7:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    ecyc = 0;
    rng_bad = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();

    // Four-sample run, then an immediate replay started in the done cycle
    load(8'd5); load(8'd200); load(8'd17); load(8'd99);
    kick();
    check("t2_go", 32'(go), 32'd1);
    check("t2_first_data", 32'(data_out), 32'd5);
    step(); step();
    check("t2_no_early_finish", 32'(finish), 32'd0);
    step();
    check("t2_finish", 32'(finish), 32'd1);
    check("t2_last_data", 32'(data_out), 32'd99);
    step();
    check("t2_done", 32'(done), 32'd1);
    check("t2_expected", 32'(expected), 32'd195);
    check("t2_mismatch", 32'(mismatch), 32'd0);
    check("t6_gap_go", 32'(go), 32'd0);
    kick();
    check("t6_go", 32'(go), 32'd1);
    check("t6_first_data", 32'(data_out), 32'd5);
    step(); step(); step(); step();
    check("t6_done", 32'(done), 32'd1);
    check("t6_expected", 32'(expected), 32'd195);

    // Single sample is refused, two equal samples give a zero range
    do_clear();
    load(8'd42);
    kick();
    check("t3_reject", 32'(reject), 32'd1);
    check("t3_no_go", 32'(go), 32'd0);
    load(8'd42);
    kick();
    wait_done("t3_done_timeout");
    check("t3_expected", 32'(expected), 32'd0);

    // Error reported mid-run with a correct range
    do_clear();
    load(8'd10); load(8'd3); load(8'd250); load(8'd7); load(8'd60);
    kick();
    step();
    error_in = 1'b1;
    step();
    error_in = 1'b0;
    wait_done("t5_done_timeout");
    check("t5_result", 32'(result), 32'd247);
    check("t5_result_err", 32'(result_err), 32'd1);
    check("t5_mismatch", 32'(mismatch), 32'd1);

    // Full buffer drops the extra write; a 16-sample run finishes 16 cycles after start
    do_clear();
    for (int i = 0; i < DEPTH; i++) load(8'($urandom_range(0, 255)));
    load(8'd77);
    check("t4_count", 32'(count), 32'd16);
    check("t4_wr_ready", 32'(wr_ready), 32'd0);
    kick();
    for (int i = 0; i < 15; i++) step();
    check("t4_finish", 32'(finish), 32'd1);
    step();
    check("t4_done", 32'(done), 32'd1);

    // Reset in the middle of a run
    do_clear();
    load(8'd1); load(8'd2); load(8'd3); load(8'd4);
    kick();
    step();
    reset = 1'b1;
    step();
    check("t1_go", 32'(go), 32'd0);
    check("t1_finish", 32'(finish), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    check("t1_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    step();

    // Randomised traffic, including corrupted ranges, errors and rare resets
    for (int i = 0; i < 1500; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data  = 8'($urandom_range(0, 255));
      clear    = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 7) == 0);
      error_in = ($urandom_range(0, 29) == 0);
      rng_bad  = ($urandom_range(0, 4) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    wr_valid = 1'b0; clear = 1'b0; start = 1'b0; error_in = 1'b0; reset = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
